// File: rtl/or1200_wb_mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency 32-bit SRAM between the OR1200
// instruction and data Wishbone classic masters, with out-of-window defaults.
module or1200_wb_mem_arbiter #(
  parameter int          AW       = 14,
  parameter logic [31:0] IWB_DFLT = 32'h15000000,
  parameter logic [31:0] DWB_DFLT = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst_n,
  // instruction master
  input  logic          iwb_cyc_i,
  input  logic          iwb_stb_i,
  input  logic [31:0]   iwb_adr_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  // data master
  input  logic          dwb_cyc_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_we_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [31:0]   dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o,
  // SRAM
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  // statistics
  output logic [15:0]   oor_cnt_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic OWN_IWB = 1'b0;
  localparam logic OWN_DWB = 1'b1;

  logic [1:0]    state;
  logic          last_grant;
  logic          owner;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [3:0]    lat_sel;
  logic [31:0]   lat_wdata;
  logic          lat_in_win;
  logic          iwb_ack_q;
  logic          dwb_ack_q;
  logic [15:0]   oor_cnt;

  logic iwb_req;
  logic dwb_req;
  logic iwb_in_win;
  logic dwb_in_win;
  logic grant_dwb;
  logic in_access;

  // Byte-offset bits never reach a word-wide SRAM.
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = &{1'b0, iwb_adr_i[1:0], dwb_adr_i[1:0]};

  assign iwb_req    = iwb_cyc_i & iwb_stb_i;
  assign dwb_req    = dwb_cyc_i & dwb_stb_i;
  assign iwb_in_win = (iwb_adr_i[31:AW+2] == '0);
  assign dwb_in_win = (dwb_adr_i[31:AW+2] == '0);

  // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
  always_comb begin
    grant_dwb = 1'b0;
    if (dwb_req && (!iwb_req || last_grant == OWN_IWB))
      grant_dwb = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= OWN_DWB;
      owner      <= OWN_IWB;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_sel    <= 4'b0000;
      lat_wdata  <= 32'h0;
      lat_in_win <= 1'b0;
      iwb_ack_q  <= 1'b0;
      dwb_ack_q  <= 1'b0;
      oor_cnt    <= 16'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          iwb_ack_q <= 1'b0;
          dwb_ack_q <= 1'b0;
          if (iwb_req || dwb_req) begin
            owner      <= grant_dwb;
            last_grant <= grant_dwb;
            state      <= ST_ACCESS;
            if (grant_dwb) begin
              lat_addr   <= dwb_adr_i[AW+1:2];
              lat_we     <= dwb_we_i;
              lat_sel    <= dwb_sel_i;
              lat_wdata  <= dwb_dat_i;
              lat_in_win <= dwb_in_win;
            end else begin
              lat_addr   <= iwb_adr_i[AW+1:2];
              lat_we     <= 1'b0;
              lat_sel    <= 4'b0000;
              lat_wdata  <= 32'h0;
              lat_in_win <= iwb_in_win;
            end
          end
        end
        ST_ACCESS: begin
          if (!lat_in_win && oor_cnt != 16'hFFFF)
            oor_cnt <= oor_cnt + 16'd1;
          // A master that abandoned its cycle during the access gets no acknowledge.
          iwb_ack_q <= (owner == OWN_IWB) & iwb_cyc_i;
          dwb_ack_q <= (owner == OWN_DWB) & dwb_cyc_i;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          iwb_ack_q <= 1'b0;
          dwb_ack_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          iwb_ack_q <= 1'b0;
          dwb_ack_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_access   = (state == ST_ACCESS);
  assign mem_en_o    = in_access & lat_in_win;
  assign mem_we_o    = mem_en_o ? ({4{lat_we}} & lat_sel) : 4'b0000;
  assign mem_addr_o  = mem_en_o ? lat_addr : '0;
  assign mem_wdata_o = mem_en_o ? lat_wdata : 32'h0;

  // Read data arrives the cycle after the access, i.e. together with the registered ack.
  always_comb begin
    iwb_dat_o = 32'h0;
    dwb_dat_o = 32'h0;
    if (iwb_ack_q)
      iwb_dat_o = lat_in_win ? mem_rdata_i : IWB_DFLT;
    if (dwb_ack_q && !lat_we)
      dwb_dat_o = lat_in_win ? mem_rdata_i : DWB_DFLT;
  end

  assign iwb_ack_o = iwb_ack_q;
  assign dwb_ack_o = dwb_ack_q;
  assign oor_cnt_o = oor_cnt;

endmodule
